// File: rtl/small_mac_array.sv
// Lane-parallel multiply-accumulate engine for small sign-magnitude secrets.
// Each beat broadcasts one coefficient to every lane; the accumulators are then drained one lane at a time.
module small_mac_array #(
    parameter int LANES  = 4,
    parameter int W      = 13,
    parameter int SW     = 4,
    parameter int MAXMAG = 4,
    parameter int BW     = 9,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_start_clear,
    input  logic [BW-1:0]         i_start_beats,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [W-1:0]          i_in_a,
    input  logic [LANES*SW-1:0]   i_in_s,
    input  logic                  i_in_neg,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [W-1:0]          o_out_data,
    output logic [LW-1:0]         o_out_lane,
    output logic                  o_done,
    output logic                  o_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [SW-2:0] MAXMAG_L = (SW-1)'(MAXMAG);

    state_t          r_state;
    state_t          w_state_next;
    logic [BW-1:0]   r_beats;
    logic [BW-1:0]   r_cnt;
    logic [LW-1:0]   r_idx;
    logic [W-1:0]    r_acc  [LANES];
    logic [W-1:0]    r_prod [LANES];
    logic [LANES-1:0] r_sub;
    logic            r_v1;
    logic            r_err;
    logic            r_done;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_drain_hs;
    logic            w_last_lane;
    logic            w_bad;
    logic            w_start_ok;

    // Out-of-range magnitudes contribute nothing; the caller flags them separately.
    function automatic logic [W-1:0] lane_prod(input logic [W-1:0] a, input logic [SW-2:0] mag);
        logic [W-1:0] m;
        m = W'(mag);
        if (mag > MAXMAG_L) begin
            lane_prod = '0;
        end else begin
            lane_prod = a * m;
        end
    endfunction

    assign w_in_ready  = (r_state == S_ACCUM) && (r_cnt < r_beats);
    assign w_accept    = i_in_valid && w_in_ready;
    assign w_drain_hs  = (r_state == S_DRAIN) && i_out_ready;
    assign w_last_lane = (r_idx == LW'(LANES-1));
    assign w_start_ok  = (r_state == S_IDLE) && i_start;

    // Detect any lane in the current beat whose secret magnitude is out of range.
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            w_bad = w_bad | (i_in_s[i*SW +: SW-1] > MAXMAG_L);
        end
    end

    // Next-state decode; beats=0 falls straight through to FLUSH.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_next = S_ACCUM;
                else         w_state_next = S_IDLE;
            end
            S_ACCUM: begin
                if (r_cnt == r_beats)                                w_state_next = S_FLUSH;
                else if (w_accept && ((r_cnt + BW'(1)) == r_beats))  w_state_next = S_FLUSH;
                else                                                 w_state_next = S_ACCUM;
            end
            S_FLUSH: w_state_next = S_DRAIN;
            S_DRAIN: begin
                if (w_drain_hs && w_last_lane) w_state_next = S_IDLE;
                else                           w_state_next = S_DRAIN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Control state: FSM, beat counter, drain index, sticky error, done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_beats <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_drain_hs && w_last_lane;
            if (w_start_ok) begin
                r_beats <= i_start_beats;
                r_cnt   <= '0;
                if (i_start_clear) r_err <= 1'b0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + BW'(1);
                if (w_bad) r_err <= 1'b1;
            end
            if (r_state == S_FLUSH) begin
                r_idx <= '0;
            end else if (w_drain_hs) begin
                r_idx <= w_last_lane ? LW'(0) : (r_idx + LW'(1));
            end
        end
    end

    // Two-stage datapath: products registered at accept, folded into accumulators one edge later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1  <= 1'b0;
            r_sub <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
                r_acc[i]  <= '0;
            end
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                for (int i = 0; i < LANES; i++) begin
                    r_prod[i] <= lane_prod(i_in_a, i_in_s[i*SW +: SW-1]);
                    r_sub[i]  <= i_in_s[i*SW + SW-1] ^ i_in_neg;
                end
            end
            if (w_start_ok && i_start_clear) begin
                for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
            end else if (r_v1) begin
                for (int i = 0; i < LANES; i++) begin
                    r_acc[i] <= r_sub[i] ? (r_acc[i] - r_prod[i]) : (r_acc[i] + r_prod[i]);
                end
            end
        end
    end

    // Drain data is forced to zero outside DRAIN so idle outputs are clean.
    always_comb begin
        o_out_data = '0;
        if (r_state == S_DRAIN) o_out_data = r_acc[r_idx];
        else                    o_out_data = '0;
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = (r_state == S_DRAIN);
    assign o_out_lane  = r_idx;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_small_mac_array.sv
// Scoreboard bench for small_mac_array: expected drain words are queued when a job is issued
// and a monitor pops and compares them on every drain handshake.
module tb_small_mac_array;

    localparam int LANES = 4, W = 13, SW = 4, MAXMAG = 4, BW = 9, LW = 2;

    logic                clk = 1'b0;
    logic                i_rst, i_start, i_start_clear, i_in_valid, i_in_neg, i_out_ready;
    logic [BW-1:0]       i_start_beats;
    logic [W-1:0]        i_in_a;
    logic [LANES*SW-1:0] i_in_s;
    logic                o_in_ready, o_out_valid, o_done, o_err;
    logic [W-1:0]        o_out_data;
    logic [LW-1:0]       o_out_lane;

    int n_checks = 0;
    int n_fail   = 0;
    logic stall_en  = 1'b0;
    int   stall_cnt = 0;

    typedef struct packed {
        logic [LW-1:0] lane;
        logic [W-1:0]  data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    small_mac_array #(.LANES(LANES), .W(W), .SW(SW), .MAXMAG(MAXMAG), .BW(BW)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_start_clear(i_start_clear),
        .i_start_beats(i_start_beats), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_a(i_in_a), .i_in_s(i_in_s), .i_in_neg(i_in_neg), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_out_data(o_out_data), .o_out_lane(o_out_lane),
        .o_done(o_done), .o_err(o_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push4(input int e0, input int e1, input int e2, input int e3);
        exp_q.push_back('{lane: 2'd0, data: W'(e0)});
        exp_q.push_back('{lane: 2'd1, data: W'(e1)});
        exp_q.push_back('{lane: 2'd2, data: W'(e2)});
        exp_q.push_back('{lane: 2'd3, data: W'(e3)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic clear, input logic [BW-1:0] beats);
        i_start = 1'b1; i_start_clear = clear; i_start_beats = beats;
        tick();
        i_start = 1'b0; i_start_clear = 1'b0;
    endtask

    task automatic send_beat(input logic [W-1:0] a, input logic [15:0] s, input logic neg,
                             input logic hold_valid);
        logic ok;
        ok = 1'b0;
        i_in_valid = 1'b1; i_in_a = a; i_in_s = s; i_in_neg = neg;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (o_in_ready) begin
                tick();
                ok = 1'b1;
            end
        end
        check("beat accepted", ok, 1'b1);
        if (!hold_valid || !ok) i_in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
        end
        check({"done ", name}, seen, 1'b1);
        check({"scoreboard drained ", name}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Downstream ready: optionally stall 3 cycles while lane 1 is presented.
    initial begin
        i_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (stall_en && o_out_valid && o_out_lane == 2'd1 && stall_cnt < 3) begin
                i_out_ready = 1'b0;
                stall_cnt++;
            end else begin
                i_out_ready = 1'b1;
            end
        end
    end

    // Monitor: compare each drain handshake, and stalled outputs against the pending entry.
    always @(negedge clk) begin
        if (o_out_valid && i_out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected drain beat", 1'b1, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("drain lane", o_out_lane, mon_e.lane);
                check("drain data", o_out_data, mon_e.data);
            end
        end else if (o_out_valid && !i_out_ready && exp_q.size() != 0) begin
            check("stall hold lane", o_out_lane, exp_q[0].lane);
            check("stall hold data", o_out_data, exp_q[0].data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_start_clear = 1'b0; i_start_beats = '0;
        i_in_valid = 1'b0; i_in_a = '0; i_in_s = '0; i_in_neg = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", o_in_ready, 1'b0);
        check("reset out_valid", o_out_valid, 1'b0);
        check("reset out_data", o_out_data, 13'd0);
        check("reset out_lane", o_out_lane, 2'd0);
        check("reset done", o_done, 1'b0);
        check("reset err", o_err, 1'b0);
        @(posedge clk); #1;
        i_rst = 1'b0;

        // Basic broadcast multiply
        push4(100, 200, 300, 400);
        start_job(1'b1, 9'd1);
        check("in_ready after start", o_in_ready, 1'b1);
        send_beat(13'd100, {4'h4, 4'h3, 4'h2, 4'h1}, 1'b0, 1'b0);
        check("in_ready after last beat", o_in_ready, 1'b0);
        wait_done("basic");

        // Modular subtract, then chained add back to zero
        push4(8172, 0, 0, 0);
        start_job(1'b1, 9'd1);
        send_beat(13'd5, {4'h0, 4'h0, 4'h0, 4'hC}, 1'b0, 1'b0);
        wait_done("sub");
        push4(0, 0, 0, 0);
        start_job(1'b0, 9'd1);
        send_beat(13'd5, {4'h0, 4'h0, 4'h0, 4'h4}, 1'b0, 1'b0);
        wait_done("chain");

        // Negacyclic flip; lane 2 carries -0
        push4(8171, 21, 0, 0);
        start_job(1'b1, 9'd1);
        send_beat(13'd7, {4'h0, 4'h8, 4'hB, 4'h3}, 1'b1, 1'b0);
        wait_done("neg");

        // Gaps between beats, valid held after the last beat, stall on lane 1
        stall_en = 1'b1; stall_cnt = 0;
        push4(5, 21, 22, 38);
        start_job(1'b1, 9'd3);
        send_beat(13'd10, {4'h4, 4'h3, 4'h2, 4'h1}, 1'b0, 1'b0);
        repeat (2) tick();
        send_beat(13'd3, {4'h0, 4'hA, 4'h1, 4'h9}, 1'b0, 1'b0);
        repeat (2) tick();
        send_beat(13'd2, {4'h1, 4'h1, 4'h1, 4'h1}, 1'b1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("no beat past count", o_in_ready, 1'b0);
        end
        i_in_valid = 1'b0;
        wait_done("backpressure");
        check("stall cycles applied", stall_cnt, 3);
        stall_en = 1'b0;

        // Illegal magnitude on lane 2; err sticky through chain, cleared by start_clear
        push4(9, 18, 0, 27);
        start_job(1'b1, 9'd1);
        check("err before bad beat", o_err, 1'b0);
        send_beat(13'd9, {4'h3, 4'h5, 4'h2, 4'h1}, 1'b0, 1'b0);
        check("err after bad beat", o_err, 1'b1);
        wait_done("illegal");
        push4(10, 19, 1, 28);
        start_job(1'b0, 9'd1);
        send_beat(13'd1, {4'h1, 4'h1, 4'h1, 4'h1}, 1'b0, 1'b0);
        wait_done("illegal chain");
        check("err sticky", o_err, 1'b1);
        push4(0, 0, 0, 0);
        start_job(1'b1, 9'd0);
        check("err cleared by start_clear", o_err, 1'b0);
        wait_done("clear zero beats");

        // Reset in the middle of ACCUM discards the job
        start_job(1'b1, 9'd2);
        send_beat(13'd50, {4'h1, 4'h1, 4'h1, 4'h1}, 1'b0, 1'b0);
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("in_ready after rst", o_in_ready, 1'b0);
        check("out_valid after rst", o_out_valid, 1'b0);
        repeat (2) tick();

        // Fresh job from zeroed accumulators; start pulsed during drain is ignored
        push4(1, 2, 3, 4);
        start_job(1'b0, 9'd1);
        send_beat(13'd1, {4'h4, 4'h3, 4'h2, 4'h1}, 1'b0, 1'b0);
        for (int c = 0; c < 20 && !o_out_valid; c++) @(negedge clk);
        check("drain started", o_out_valid, 1'b1);
        i_start = 1'b1; i_start_clear = 1'b1; i_start_beats = 9'd1;
        tick();
        i_start = 1'b0; i_start_clear = 1'b0;
        wait_done("after rst");
        repeat (4) begin
            @(negedge clk);
            check("no job from ignored start", {o_in_ready, o_out_valid}, 2'b00);
        end

        // beats=0 drains unchanged accumulators
        push4(1, 2, 3, 4);
        start_job(1'b0, 9'd0);
        check("beats0 in_ready", o_in_ready, 1'b0);
        wait_done("beats0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
